demod_segment_ctrl_param: RTL and testbench

//  Parametrised successor to the fixed 10-segment demodulation control wrapper.
//  - Captures one IN_W-bit modulated word on start and slices it into NUM_SEG symbols of SYM_W bits each.
//  - Gray-to-binary demaps each symbol and presents the result after LATENCY cycles, qualified by valid.
//  - Adds output back-pressure (out_ready), a continuous mode and a delivered-frame counter.
//  - Sits between the modulated-bit source and the segment consumers in the modulation pipe.

---
 rtl/demod_segment_ctrl_param.sv | 138 +++++++++++++
 tb/tb_demod_segment_ctrl_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/demod_segment_ctrl_param.sv
// Captures a modulated word, slices it into NUM_SEG Gray-coded symbols and presents the demapped segments.
// Latency: valid visible LATENCY-1 edges after the capture edge; the result is held until the consumer accepts it.
// Backpressure: out_ready=0 freezes the result in HOLD; start is ignored there until the result is accepted.
module demod_segment_ctrl_param #(
    parameter int IN_W    = 32,
    parameter int SYM_W   = 2,
    parameter int NUM_SEG = 10,
    parameter int SEG_W   = 32,
    parameter int LATENCY = 3,
    parameter int FCNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IN_W-1:0]          input_bit,
    input  logic                     start,
    input  logic                     continuous,
    input  logic                     out_ready,
    output logic [NUM_SEG*SEG_W-1:0] segments,
    output logic                     valid,
    output logic                     busy,
    output logic [FCNT_W-1:0]        frame_cnt
);

    localparam int USED_W = NUM_SEG * SYM_W;
    localparam int CNT_W  = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [USED_W-1:0]   cap_q;
    logic                capture;
    logic                load_seg;
    logic                accept;

    // Bits of input_bit above the symbol field carry no symbols.
    logic unused_in;
    assign unused_in = ^input_bit;

    function automatic logic [NUM_SEG*SEG_W-1:0] demap(input logic [USED_W-1:0] w);
        logic [NUM_SEG*SEG_W-1:0] r;
        logic [SYM_W-1:0]         g;
        logic [SYM_W-1:0]         b;
        r = '0;
        for (int k = 0; k < NUM_SEG; k++) begin
            g = w[k*SYM_W +: SYM_W];
            b[SYM_W-1] = g[SYM_W-1];
            for (int i = SYM_W - 2; i >= 0; i--) begin
                b[i] = b[i+1] ^ g[i];
            end
            r[k*SEG_W +: SEG_W] = SEG_W'(b);
        end
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        load_seg  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    cnt_nxt   = CNT_ONE;
                    state_nxt = (LATENCY == 1) ? HOLD : RUN;
                end
            end
            RUN: begin
                if (!start) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    load_seg  = 1'b1;
                    cnt_nxt   = CNT_FULL;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    accept = 1'b1;
                    if (continuous && start) begin
                        capture   = 1'b1;
                        cnt_nxt   = CNT_ONE;
                        state_nxt = (LATENCY == 1) ? HOLD : RUN;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_q     <= '0;
            segments  <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            valid <= (state_nxt == HOLD);
            busy  <= (state_nxt == RUN);
            if (capture) begin
                cap_q <= input_bit[USED_W-1:0];
            end
            // With a single-cycle latency the result is demapped straight off the input.
            if (capture && (LATENCY == 1)) begin
                segments <= demap(input_bit[USED_W-1:0]);
            end else if (load_seg) begin
                segments <= demap(cap_q);
            end
            if (accept) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_demod_segment_ctrl_param.sv
// Bench for demod_segment_ctrl_param: default instance plus a LATENCY=1 / FCNT_W=2 instance on shared inputs.
module tb_demod_segment_ctrl_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [31:0]   input_bit;
    logic          start, continuous, out_ready;
    logic [319:0]  seg0, seg1;
    logic          v0, b0, v1, b1;
    logic [15:0]   fc0;
    logic [1:0]    fc1;

    demod_segment_ctrl_param dut (
        .clk(clk), .reset(reset), .input_bit(input_bit), .start(start),
        .continuous(continuous), .out_ready(out_ready),
        .segments(seg0), .valid(v0), .busy(b0), .frame_cnt(fc0)
    );

    demod_segment_ctrl_param #(.LATENCY(1), .FCNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .input_bit(input_bit), .start(start),
        .continuous(continuous), .out_ready(out_ready),
        .segments(seg1), .valid(v1), .busy(b1), .frame_cnt(fc1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Timestamp model: a captured word becomes visible at cycle capture+LATENCY-1.
    longint       cyc = 0;
    int           m_ph[2];   // 0 idle, 1 converting, 2 result held
    longint       m_due[2];
    logic [31:0]  m_cap[2];
    logic [319:0] m_seg[2];
    int           m_fc[2];
    int           lat[2]  = '{3, 1};
    int           fmod[2] = '{65536, 4};

    typedef struct {
        logic        st, co, rdy;
        logic [31:0] in;
        logic        ev, eb;
        logic [15:0] ef;
        logic [31:0] es0, es1;
    } vec_t;
    vec_t vt[12];

    function automatic logic [319:0] ref_demap(input logic [31:0] w);
        logic [319:0] r;
        int g, b;
        r = '0;
        for (int k = 0; k < 10; k++) begin
            g = int'((w >> (2 * k)) & 32'd3);
            b = g;
            for (int i = 1; i < 2; i++) b = b ^ (g >> i);
            r = r | (320'(b) << (32 * k));
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic m_capture(input int i);
        m_cap[i] = input_bit;
        m_due[i] = cyc + lat[i] - 1;
        if (m_due[i] == cyc) begin
            m_seg[i] = ref_demap(input_bit);
            m_ph[i]  = 2;
        end else begin
            m_ph[i] = 1;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_ph[i] = 0; m_seg[i] = '0; m_fc[i] = 0;
            end else begin
                case (m_ph[i])
                    2: if (out_ready) begin
                        m_fc[i] = (m_fc[i] + 1) % fmod[i];
                        if (continuous && start) m_capture(i);
                        else m_ph[i] = 0;
                    end
                    1: if (!start) m_ph[i] = 0;
                       else if (cyc == m_due[i]) begin
                           m_seg[i] = ref_demap(m_cap[i]);
                           m_ph[i]  = 2;
                       end
                    default: if (start) m_capture(i);
                endcase
            end
        end
        cyc++;
    endtask

    task automatic check_model();
        chk("m0_valid", v0,  m_ph[0] == 2);
        chk("m0_busy",  b0,  m_ph[0] == 1);
        chk("m0_seg",   seg0, m_seg[0]);
        chk("m0_fcnt",  fc0, m_fc[0]);
        chk("m1_valid", v1,  m_ph[1] == 2);
        chk("m1_busy",  b1,  m_ph[1] == 1);
        chk("m1_seg",   seg1, m_seg[1]);
        chk("m1_fcnt",  fc1, m_fc[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    logic [319:0] exp_seg;
    logic [15:0]  fbase;
    int           nvalid;

    initial begin
        vt[0]  = '{1'b1, 1'b0, 1'b1, 32'h6, 1'b0, 1'b1, 16'd0, 32'd0, 32'd0};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 32'h6, 1'b0, 1'b1, 16'd0, 32'd0, 32'd0};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 32'h6, 1'b1, 1'b0, 16'd0, 32'd3, 32'd1};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 32'h6, 1'b0, 1'b0, 16'd1, 32'd3, 32'd1};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 32'h6, 1'b0, 1'b1, 16'd1, 32'd3, 32'd1};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 32'h6, 1'b0, 1'b0, 16'd1, 32'd3, 32'd1};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 32'h6, 1'b0, 1'b0, 16'd1, 32'd3, 32'd1};
        vt[7]  = '{1'b1, 1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 16'd1, 32'd3, 32'd1};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 16'd1, 32'd3, 32'd1};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 32'hB, 1'b1, 1'b0, 16'd1, 32'd2, 32'd3};
        vt[10] = '{1'b1, 1'b0, 1'b0, 32'h5, 1'b1, 1'b0, 16'd1, 32'd2, 32'd3};
        vt[11] = '{1'b0, 1'b0, 1'b1, 32'h5, 1'b0, 1'b0, 16'd2, 32'd2, 32'd3};

        reset = 1'b0; start = 1'b1; continuous = 1'b0; out_ready = 1'b1;
        input_bit = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("rst_valid", v0, 1'b0);
        chk("rst_busy",  b0, 1'b0);
        chk("rst_seg",   seg0, '0);
        chk("rst_fcnt",  fc0, '0);
        chk("rst1_valid", v1, 1'b0);
        chk("rst1_fcnt",  fc1, '0);
        reset = 1'b1;

        // Basic frame, single-shot re-arm, abort, then a held result.
        for (int s = 0; s < 12; s++) begin
            start = vt[s].st; continuous = vt[s].co; out_ready = vt[s].rdy;
            input_bit = vt[s].in;
            tick();
            chk($sformatf("vec%0d_valid", s), v0, vt[s].ev);
            chk($sformatf("vec%0d_busy", s),  b0, vt[s].eb);
            chk($sformatf("vec%0d_fcnt", s),  fc0, vt[s].ef);
            chk($sformatf("vec%0d_seg0", s),  seg0[31:0], vt[s].es0);
            chk($sformatf("vec%0d_seg1", s),  seg0[63:32], vt[s].es1);
        end
        chk("basic_seg_hi", seg0[319:64], '0);

        // Back-pressure with a changing input word.
        reset_pulse();
        start = 1'b1; continuous = 1'b0; out_ready = 1'b1;
        input_bit = 32'h000F_A5C3;
        exp_seg = ref_demap(32'h000F_A5C3);
        tick(); tick(); tick();
        chk("bp_valid_on", v0, 1'b1);
        out_ready = 1'b0;
        fbase = fc0;
        for (int c = 0; c < 5; c++) begin
            input_bit = $urandom;
            tick();
            chk("bp_valid", v0, 1'b1);
            chk("bp_seg",   seg0, exp_seg);
            chk("bp_fcnt",  fc0, fbase);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_accept_fcnt", fc0, fbase + 16'd1);

        // Continuous with out_ready high: one frame every 3 cycles.
        reset_pulse();
        start = 1'b1; continuous = 1'b1; out_ready = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 30; c++) begin
            input_bit = $urandom;
            tick();
            if (v0) nvalid++;
        end
        chk("cont_nvalid", 320'(nvalid), 320'd10);
        tick();
        chk("cont_fcnt", fc0, 16'd10);

        // LATENCY=1: valid right after the capture edge; 2-bit counter wraps.
        reset_pulse();
        start = 1'b1; continuous = 1'b1; out_ready = 1'b1;
        input_bit = 32'h0003_9E27;
        tick();
        chk("lat1_valid", v1, 1'b1);
        chk("lat1_seg",   seg1, ref_demap(32'h0003_9E27));
        for (int c = 0; c < 5; c++) begin
            input_bit = $urandom;
            tick();
        end
        chk("lat1_wrap_fcnt", fc1, 2'd1);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            reset      = ($urandom_range(0, 99) >= 2);
            start      = ($urandom_range(0, 99) < 85);
            continuous = $urandom_range(0, 1);
            out_ready  = ($urandom_range(0, 99) < 70);
            input_bit  = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
